// File: rtl/fpdiv_scheduler.sv
// Round-robin scheduler sharing one FP divider core among NUM_REQ requesters.
// Zero divisors bypass the core; a watchdog aborts a core that never answers.
module fpdiv_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                  g_clk,
  input  logic                  n_reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_dividend,
  input  logic [32*NUM_REQ-1:0] req_divisor,
  output logic                  div_start,
  output logic [31:0]           div_dividend,
  output logic [31:0]           div_divisor,
  output logic                  div_abort,
  input  logic                  div_done,
  input  logic [31:0]           div_quotient,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_quotient,
  output logic                  rsp_dbz,
  output logic                  rsp_timeout
);

  localparam int unsigned DW   = 32;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       dvd_q, dvd_d;
  logic [31:0]       dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       quot_q, quot_d;
  logic              dbz_q, dbz_d;
  logic              tout_q, tout_d;

  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic [31:0]       sel_dvd, sel_dvs;

  // Lowest valid index above last_grant wins; otherwise wrap to lowest valid.
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) > last_grant_q)) begin
        grant_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign sel_dvd = req_dividend[DW*32'(grant_id) +: DW];
  assign sel_dvs = req_divisor[DW*32'(grant_id) +: DW];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    quot_d       = quot_q;
    dbz_d        = dbz_q;
    tout_d       = tout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          rsp_id_d = grant_id;
          dvd_d    = sel_dvd;
          dvs_d    = sel_dvs;
          dbz_d    = 1'b0;
          tout_d   = 1'b0;
          if (sel_dvs[30:0] == 31'd0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            dbz_d       = 1'b1;
            quot_d      = (sel_dvd[30:0] == 31'd0) ? QNAN
                                                   : {sel_dvd[31] ^ sel_dvs[31], 8'hFF, 23'd0};
          end else begin
            state_d = S_ISSUE;
            start_d = 1'b1;
            cnt_d   = CNT_W'(TIMEOUT - 1);
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WAIT: begin
        // A done arriving on the last counted cycle still beats the watchdog.
        if (div_done) begin
          quot_d      = div_quotient;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == '0) begin
          abort_d     = 1'b1;
          quot_d      = '0;
          tout_d      = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      quot_q       <= '0;
      dbz_q        <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      rsp_valid_q  <= rsp_valid_d;
      quot_q       <= quot_d;
      dbz_q        <= dbz_d;
      tout_q       <= tout_d;
    end
  end

  assign div_start    = start_q;
  assign div_abort    = abort_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_quotient = quot_q;
  assign rsp_dbz      = dbz_q;
  assign rsp_timeout  = tout_q;

endmodule

// File: tb/tb_fpdiv_scheduler.sv
// Bench for fpdiv_scheduler: transaction/timestamp reference model, emulated core,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fpdiv_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic                  g_clk;
  logic                  n_reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_dividend;
  logic [32*NUM_REQ-1:0] req_divisor;
  logic                  div_start;
  logic [31:0]           div_dividend;
  logic [31:0]           div_divisor;
  logic                  div_abort;
  logic                  div_done;
  logic [31:0]           div_quotient;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_quotient;
  logic                  rsp_dbz;
  logic                  rsp_timeout;

  fpdiv_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .g_clk(g_clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_abort(div_abort), .div_done(div_done), .div_quotient(div_quotient),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Requester stubs
  logic [NUM_REQ-1:0] p_valid;
  logic [31:0]        p_dvd [NUM_REQ];
  logic [31:0]        p_dvs [NUM_REQ];

  // Scenario controls
  bit          rr, rst_drive, hold_all, stray_en, stray_force, fix_q_en;
  int          lat_mode;   // -2 random, -1 core never answers, else fixed latency
  logic [31:0] fix_q;

  // Reference model: one transaction described by event timestamps
  bit          m_busy, m_byp;
  int          m_last, m_id, m_start, m_done, m_resp, m_abort;
  logic [31:0] m_dd, m_ds, m_q, m_cq;
  bit          m_dbz, m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_byp = 0; m_last = NUM_REQ - 1; m_id = 0;
    m_start = -1; m_done = -1; m_resp = -1; m_abort = -1;
    m_dd = '0; m_ds = '0; m_q = '0; m_cq = '0; m_dbz = 0; m_to = 0;
  endtask

  // One clock cycle: drive at negedge, compare all outputs, advance the model.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    bit in_wait, drove_done, exp_rv;
    int g, idx, lat;
    @(negedge g_clk);
    n_reset = !rst_drive;
    if (rst_drive) begin
      p_valid = '0;
      model_reset();
    end else if (hold_all) begin
      p_valid = '1;
    end
    req_valid = p_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dividend[32*i +: 32] = p_dvd[i];
      req_divisor[32*i +: 32]  = p_dvs[i];
    end
    rsp_ready  = rr;
    in_wait    = m_busy && !m_byp && (cyc > m_start) && (m_resp < 0);
    drove_done = 0;
    div_done   = 1'b0;
    div_quotient = $urandom;
    if (in_wait) begin
      if (cyc == m_done) begin
        div_done = 1'b1; div_quotient = m_cq; drove_done = 1;
      end
    end else if (stray_force || (stray_en && $urandom_range(0, 5) == 0)) begin
      div_done = 1'b1;
      stray_force = 0;
    end
    #1;
    exp_rdy = '0;
    g = -1;
    if (!m_busy && n_reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_last + k) % NUM_REQ;
        if (g < 0 && p_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = m_busy && (m_resp >= 0) && (cyc >= m_resp);

    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("div_start", 32'(div_start), 32'(m_busy && !m_byp && cyc == m_start));
    chk("div_abort", 32'(div_abort), 32'(cyc == m_abort));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("div_dividend", div_dividend, m_dd);
    chk("div_divisor", div_divisor, m_ds);
    if (exp_rv || !n_reset) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_quotient", rsp_quotient, m_q);
      chk("rsp_dbz", 32'(rsp_dbz), 32'(m_dbz));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
    end

    if (exp_rv && rr) begin
      m_busy = 0;
      m_last = m_id;
    end else if (in_wait) begin
      if (drove_done) begin
        m_resp = cyc + 1; m_q = m_cq; m_to = 0; m_dbz = 0;
      end else if (cyc == m_start + TIMEOUT - 1) begin
        m_abort = cyc + 1; m_resp = cyc + 1; m_q = '0; m_to = 1; m_dbz = 0;
      end
    end else if (g >= 0) begin
      m_busy = 1; m_id = g; m_dd = p_dvd[g]; m_ds = p_dvs[g];
      p_valid[g] = 1'b0;
      if (m_ds[30:0] == 31'd0) begin
        m_byp = 1; m_start = -1; m_resp = cyc + 1; m_dbz = 1; m_to = 0;
        m_q = (m_dd[30:0] == 31'd0) ? 32'h7FC00000 : {m_dd[31] ^ m_ds[31], 8'hFF, 23'd0};
      end else begin
        m_byp = 0; m_start = cyc + 1; m_resp = -1;
        if (lat_mode != -2) lat = lat_mode;
        else case ($urandom_range(0, 7))
          0:       lat = TIMEOUT - 1;
          1:       lat = -1;
          default: lat = $urandom_range(1, 10);
        endcase
        m_done = (lat >= 1 && lat <= TIMEOUT - 1) ? m_start + lat : -1;
        m_cq   = fix_q_en ? fix_q : 32'($urandom);
      end
    end
    cyc++;
  endtask

  function automatic bit probe(input int which);
    case (which)
      0:       return rsp_valid;
      1:       return div_start;
      2:       return div_abort;
      default: return |req_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      step();
      if (probe(which)) begin
        at = cyc - 1;
        break;
      end
    end
    n_chk++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL wait_sig%0d: not seen within %0d cycles", which, budget);
    end
  endtask

  task automatic reset_dut();
    rst_drive = 1;
    repeat (2) step();
    rst_drive = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    p_valid = '0; hold_all = 0; rr = 1;
    while (m_busy && n < 300) begin
      step();
      n++;
    end
    step();
    chk("drain_idle", 32'(m_busy), 32'd0);
  endtask

  task automatic new_req(input int i);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r[30:0] = '0;
    p_dvd[i] = r;
    r = $urandom;
    if ($urandom_range(0, 5) == 0) r[30:0] = '0;
    p_dvs[i] = r;
    p_valid[i] = 1'b1;
  endtask

  int at, s, gid;
  int exp_ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_reset = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    div_done = 1'b0; div_quotient = '0; rsp_ready = 1'b0;
    p_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin p_dvd[i] = 32'h3F800000; p_dvs[i] = 32'h40000000; end
    rr = 0; rst_drive = 0; hold_all = 0; stray_en = 0; stray_force = 0;
    fix_q_en = 0; fix_q = '0; lat_mode = -2;
    model_reset();

    // Single request from requester 2: 6.0 / 2.0
    reset_dut();
    lat_mode = 5; fix_q_en = 1; fix_q = 32'h40400000;
    p_dvd[2] = 32'h40C00000; p_dvs[2] = 32'h40000000; p_valid[2] = 1'b1;
    step();
    chk("t1_grant", 32'(req_ready), 32'h4);
    step();
    chk("t1_start", 32'(div_start), 32'd1);
    chk("t1_operand", div_dividend, 32'h40C00000);
    wait_sig(0, 20, at);
    chk("t1_id", 32'(rsp_id), 32'd2);
    chk("t1_quot", rsp_quotient, 32'h40400000);
    repeat (3) step();
    chk("t1_hold", 32'(rsp_valid), 32'd1);
    chk("t1_hold_quot", rsp_quotient, 32'h40400000);
    rr = 1;
    step();
    step();
    chk("t1_released", 32'(rsp_valid), 32'd0);

    // All four requesting continuously: round-robin order from reset
    reset_dut();
    lat_mode = 2; fix_q_en = 0; rr = 1; hold_all = 1;
    for (int t = 0; t < 5; t++) begin
      wait_sig(3, 30, at);
      gid = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
      chk("t2_order", 32'(gid), 32'(exp_ord[t]));
    end
    drain();

    // Negative-zero divisor bypasses the core; 0/0 gives the quiet NaN
    rr = 0;
    p_dvd[1] = 32'h3F800000; p_dvs[1] = 32'h80000000; p_valid[1] = 1'b1;
    step();
    chk("t3_grant", 32'(req_ready), 32'h2);
    step();
    chk("t3_nostart", 32'(div_start), 32'd0);
    chk("t3_valid", 32'(rsp_valid), 32'd1);
    chk("t3_quot", rsp_quotient, 32'hFF800000);
    chk("t3_dbz", 32'(rsp_dbz), 32'd1);
    rr = 1;
    step();
    p_dvd[1] = 32'h80000000; p_dvs[1] = 32'h00000000; p_valid[1] = 1'b1;
    step();
    step();
    chk("t3_nan", rsp_quotient, 32'h7FC00000);
    drain();

    // Core never answers: abort TIMEOUT cycles after start
    lat_mode = -1; rr = 0;
    p_dvd[1] = 32'h3F800000; p_dvs[1] = 32'h40000000; p_valid[1] = 1'b1;
    step();
    step();
    chk("t4_start", 32'(div_start), 32'd1);
    s = cyc - 1;
    wait_sig(2, TIMEOUT + 5, at);
    chk("t4_abort_dist", 32'(at - s), 32'(TIMEOUT));
    chk("t4_timeout", 32'(rsp_timeout), 32'd1);
    chk("t4_quot", rsp_quotient, 32'd0);
    chk("t4_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Done on the final counted cycle wins over the watchdog
    lat_mode = TIMEOUT - 1; fix_q_en = 1; fix_q = 32'h3F000000; rr = 0;
    p_dvd[0] = 32'h3F800000; p_dvs[0] = 32'h40000000; p_valid[0] = 1'b1;
    step();
    step();
    chk("t5_start", 32'(div_start), 32'd1);
    s = cyc - 1;
    wait_sig(0, TIMEOUT + 5, at);
    chk("t5_rsp_dist", 32'(at - s), 32'(TIMEOUT));
    chk("t5_noabort", 32'(div_abort), 32'd0);
    chk("t5_timeout", 32'(rsp_timeout), 32'd0);
    chk("t5_quot", rsp_quotient, 32'h3F000000);
    drain();

    // Reset while waiting on the core; then stray done; then fresh priority
    lat_mode = -1; fix_q_en = 0; rr = 0;
    p_dvd[2] = 32'h41000000; p_dvs[2] = 32'h40400000; p_valid[2] = 1'b1;
    step();
    chk("t6_grant", 32'(req_ready), 32'h4);
    repeat (10) step();
    rst_drive = 1;
    step();
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_dvd", div_dividend, 32'd0);
    step();
    rst_drive = 0; stray_force = 1;
    step();
    step();
    chk("t6_stray", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) begin p_dvd[i] = 32'h3F800000; p_dvs[i] = 32'h40000000; end
    hold_all = 1;
    step();
    chk("t6_first", 32'(req_ready), 32'h1);
    hold_all = 0;
    lat_mode = 3;
    drain();

    // Response back-pressure for 10 cycles: outputs stable, no grants
    rr = 0;
    p_valid = '1;
    p_dvd[1] = 32'h40000000; p_dvs[1] = 32'h00000000;
    step();
    chk("t7_grant", 32'(req_ready), 32'h2);
    for (int t = 0; t < 10; t++) begin
      step();
      chk("t7_valid", 32'(rsp_valid), 32'd1);
      chk("t7_quot", rsp_quotient, 32'h7F800000);
      chk("t7_noready", 32'(req_ready), 32'd0);
    end
    rr = 1;
    step();
    step();
    chk("t7_next", 32'(req_ready), 32'h4);
    drain();

    // Randomized soak
    lat_mode = -2; fix_q_en = 0; stray_en = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (p_valid[i] && $urandom_range(0, 30) == 0) p_valid[i] = 1'b0;
      end
      rr = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
